// File: rtl/conv_pkg.sv
// conv_pkg: shared image sizes and pixel type for the conv/pool pipeline
package conv_pkg;
  localparam int IMG_SIZE = 32;
  localparam int KERNEL_SIZE = 5;
  localparam int CONV_OUT_SIZE = IMG_SIZE - KERNEL_SIZE + 1;
  localparam int POOL_OUT_SIZE = CONV_OUT_SIZE / 2;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] pixel_t;
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-row buffer of pair maxima; combinational read so the
// window max completes in the same cycle as the fourth pixel.
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int DATA_W = 16,
  parameter int AW = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 stride-2 signed max pooling over a raster frame.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_2x2 #(
  parameter int IN_SIZE = conv_pkg::CONV_OUT_SIZE,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     frame_done
);
  localparam int CW = $clog2(IN_SIZE);
  localparam int HALF = IN_SIZE / 2;
  localparam int AW = HALF > 1 ? $clog2(HALF) : 1;
  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a > b ? a : b;
  endfunction
  logic [CW-1:0] col, row;
  logic [AW-1:0] addr;
  logic signed [DATA_W-1:0] pair, lb_rd, top_max, win_max, res;
  logic col_last, row_last, wr, emit;
  assign col_last = col == CW'(IN_SIZE - 1);
  assign row_last = row == CW'(IN_SIZE - 1);
  assign addr = AW'(col >> 1);
  assign wr = in_valid && col[0] && !row[0];
  assign emit = in_valid && col[0] && row[0];
  assign top_max = smax(pair, in_data);
  assign win_max = smax(top_max, lb_rd);
`ifdef MAXPOOL_RELU_EN
  assign res = win_max < 0 ? '0 : win_max;
`else
  assign res = win_max;
`endif
  pool_line_buf #(.DEPTH(HALF), .DATA_W(DATA_W), .AW(AW)) u_line_buf (
    .clk(clk),
    .we(wr),
    .waddr(addr),
    .wdata(top_max),
    .raddr(addr),
    .rdata(lb_rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      pair <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid <= emit;
      frame_done <= emit && col_last && row_last;
      if (emit) out_data <= res;
      if (in_valid) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
        if (!col[0]) pair <= in_data;
      end
    end
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: image-array reference model plus directed frames for maxpool_2x2.
module tb_maxpool_2x2;
  localparam int N = 28;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic out_valid, frame_done;
  logic signed [15:0] out_data;
  int checks = 0;
  int errors = 0;
  int img [N][N];
  int k = 0;
  int exp_q[$];
  bit expfd_q[$];
  int got[$];
  int fd[$];
  int ref_q[$];
  int last_out = 0;

  maxpool_2x2 #(.IN_SIZE(N), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: keep the accepted image and pool each 2x2 block when its last pixel lands
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k = 0;
      exp_q.delete();
      expfd_q.delete();
    end else if (in_valid) begin
      int r, c, m;
      r = k / N;
      c = k % N;
      img[r][c] = int'(in_data);
      if (r % 2 == 1 && c % 2 == 1) begin
        m = img[r-1][c-1];
        if (img[r-1][c] > m) m = img[r-1][c];
        if (img[r][c-1] > m) m = img[r][c-1];
        if (img[r][c] > m) m = img[r][c];
        exp_q.push_back(relu(m));
        expfd_q.push_back(k == N * N - 1);
      end
      k = (k + 1) % (N * N);
    end

  always @(negedge clk)
    if (!rst_n) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_data", int'(out_data), 0);
      last_out = 0;
    end else begin
      chk("valid", int'(out_valid), int'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        chk("data", int'(out_data), exp_q.pop_front());
        chk("frame_done", int'(frame_done), int'(expfd_q.pop_front()));
        got.push_back(int'(out_data));
        if (frame_done) fd.push_back(got.size() - 1);
        last_out = int'(out_data);
      end else if (!out_valid) begin
        chk("hold", int'(out_data), last_out);
        chk("done_idle", int'(frame_done), 0);
      end
    end

  function automatic int pix(input int mode, input int r, input int c);
    case (mode)
      0: return r * N + c;
      1: return ((r % 2) * 2 + (c % 2)) == ((r / 2 + c / 2) % 4) ? -2 : -5;
      default: begin
        if (r < 2 && c < 2) return (r == 0) ? (c == 0 ? 32767 : -32768) : (c == 0 ? 0 : 1);
        if (r < 2 && c < 4) return -32768;
        return 0;
      end
    endcase
  endfunction

  task automatic send(input bit v, input int d);
    in_valid = v;
    in_data = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int mode, input bit gaps);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        send(1'b1, pix(mode, r, c));
        if (gaps && c == N - 1) repeat (4) send(1'b0, 0);
      end
  endtask

  task automatic flush();
    repeat (4) send(1'b0, 0);
  endtask

  task automatic match_ref(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_count"}, got.size(), ref_q.size());
    foreach (ref_q[i]) if (i >= got.size() || got[i] != ref_q[i]) bad++;
    chk({nm, "_diffs"}, bad, 0);
  endtask

  initial begin
    #100000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b0, 0);
    got.delete(); fd.delete();
    frame(0, 1'b0);
    flush();
    chk("ramp_count", got.size(), 196);
    chk("ramp_first", got[0], 29);
    chk("ramp_last", got[195], 783);
    chk("ramp_fd_count", fd.size(), 1);
    chk("ramp_fd_idx", fd[0], 195);
    ref_q = got;
    got.delete(); fd.delete();
    frame(0, 1'b1);
    flush();
    match_ref("gaps");
    chk("gaps_fd_idx", fd.size() == 1 ? fd[0] : -1, 195);
    got.delete(); fd.delete();
    frame(1, 1'b0);
    flush();
    begin
      int bad;
      bad = 0;
`ifdef MAXPOOL_RELU_EN
      foreach (got[i]) if (got[i] != 0) bad++;
`else
      foreach (got[i]) if (got[i] != -2) bad++;
`endif
      chk("neg_count", got.size(), 196);
      chk("neg_bad", bad, 0);
    end
    got.delete(); fd.delete();
    for (int i = 0; i < 300; i++) send(1'b1, pix(0, i / N, i % N));
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) send(1'b0, 0);
    rst_n = 1'b1;
    send(1'b0, 0);
    got.delete(); fd.delete();
    frame(0, 1'b0);
    flush();
    match_ref("midrst");
    got.delete(); fd.delete();
    frame(0, 1'b0);
    frame(0, 1'b0);
    flush();
    chk("b2b_count", got.size(), 392);
    chk("b2b_fd_count", fd.size(), 2);
    chk("b2b_fd_gap", fd.size() == 2 ? fd[1] - fd[0] : -1, 196);
    chk("b2b_second_first", got.size() > 196 ? got[196] : -1, 29);
    got.delete(); fd.delete();
    frame(2, 1'b0);
    flush();
    chk("bnd_mixed", got[0], 32767);
`ifdef MAXPOOL_RELU_EN
    chk("bnd_allmin", got[1], 0);
`else
    chk("bnd_allmin", got[1], -32768);
`endif
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2.md
MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 Parameter IN_SIZE, default 28, input feature-map side length in pixels; SHALL be even and at least 2.
REQ-002 Parameter DATA_W, default 16, pixel width in bits; data is two's-complement signed.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  qualifies in_data; driven by the convolution valid generator.
REQ-006 Port in_data  input  DATA_W  convolution output pixel, raster order.
REQ-007 Port out_valid  output  1  qualifies out_data; high for exactly one cycle per pooled pixel.
REQ-008 Port out_data  output  DATA_W  pooled pixel, raster order, (IN_SIZE/2)x(IN_SIZE/2) per frame.
REQ-009 Port frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-010 Column counter col (0..IN_SIZE-1) and row counter row (0..IN_SIZE-1) SHALL advance only on cycles with in_valid=1; in_valid=0 cycles hold all state.
REQ-011 col wraps IN_SIZE-1 -> 0 and increments row; row wraps IN_SIZE-1 -> 0 on col wrap, starting the next frame with no idle cycle required.
REQ-012 Gaps of any length in in_valid, including the 4-cycle per-row gaps from upstream, SHALL NOT affect results.
REQ-013 On even col, the pixel SHALL be held in a pair register.
REQ-014 On odd col of an even row, the signed max of the pair register and in_data SHALL be written to line-buffer entry col/2.
REQ-015 On odd col of an odd row, the block SHALL compute the signed max of the pair register, in_data and line-buffer entry col/2.
REQ-016 out_data SHALL carry that result with out_valid=1 on the cycle after the accepting edge; latency is 1 cycle from the 4th window pixel.
REQ-017 out_valid SHALL be 0 on every other cycle.
REQ-018 out_data SHALL hold its last value when out_valid=0.
REQ-019 Comparison SHALL be signed; on equal values either operand may be selected, since the result is identical.
REQ-020 frame_done SHALL pulse when the output for row=IN_SIZE-1, col=IN_SIZE-1 is emitted.
REQ-021 Exactly (IN_SIZE/2)^2 outputs SHALL be produced per IN_SIZE^2 accepted inputs.

Reset
REQ-022 While rst_n=0: out_valid=0, frame_done=0, out_data=0, col=0, row=0, pair register=0.
REQ-023 Line-buffer contents need not be reset; every entry is written in an even row before it is read.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first in_valid after release is pixel (0,0).

Configuration
REQ-025 Macro MAXPOOL_RELU_EN: when defined, out_data SHALL be max(result,0), so negative results output 0.
REQ-026 When MAXPOOL_RELU_EN is undefined, out_data SHALL be the raw signed max; latency is identical in both builds.

Structure
REQ-027 Package conv_pkg SHALL hold the following:
- IMG_SIZE=32, KERNEL_SIZE=5, CONV_OUT_SIZE=IMG_SIZE-KERNEL_SIZE+1, POOL_OUT_SIZE=CONV_OUT_SIZE/2, DATA_W=16;
- typedef pixel_t, a signed DATA_W vector.
REQ-028 Sub-module pool_line_buf SHALL implement the IN_SIZE/2-entry line buffer with one write port, one read port, and a registered or combinational read chosen so that REQ-016 latency holds.

Verification
REQ-029 Ramp frame: in_data = row*28+col, continuous in_valid -> 196 outputs, first = 29, last = 783, frame_done with the 196th.
REQ-030 Negative data: all inputs -5 except one -2 per window -> every output -2 without MAXPOOL_RELU_EN, 0 with it.
REQ-031 Upstream-style gaps: 28 valid cycles then 4 idle per row, same data as REQ-029 -> identical output sequence; out_valid never high during a gap-only window.
REQ-032 Reset mid-frame: assert rst_n=0 after 300 inputs, then send a full ramp frame -> outputs match REQ-029 exactly, with no stale output.
REQ-033 Back-to-back frames: two ramp frames with no idle cycle -> 392 outputs, two frame_done pulses 196 outputs apart.
REQ-034 Boundary values: window {32767, -32768, 0, 1} -> output 32767; window all -32768 -> -32768, or 0 with MAXPOOL_RELU_EN.
